// File: rtl/fht_core.sv
// Iterative N-point Walsh-Hadamard transform engine (natural Sylvester order).
// One constant-geometry butterfly stage is reused LOG2N times on a register bank.
module fht_core #(
    parameter int IN_W  = 13,
    parameter int LOG2N = 4,
    parameter int OUT_W = IN_W + LOG2N
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         FhtStar,
    input  logic [(IN_W<<LOG2N)-1:0]     In,
    output logic                         Ready,
    output logic                         Busy,
    output logic                         Done,
    output logic [(OUT_W<<LOG2N)-1:0]    Out
);

    localparam int N  = 1 << LOG2N;
    localparam int H  = N / 2;
    localparam int CW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [OUT_W-1:0] bank [N];
    logic signed [OUT_W-1:0] nxt  [N];
    logic signed [OUT_W-1:0] ld   [N];
    logic                    last;

    assign last = (cnt == CW'(LOG2N - 1));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ld[i] = {{LOG2N{In[i*IN_W+IN_W-1]}}, In[i*IN_W +: IN_W]};
        end
    end

    // Shuffle-exchange stage: after LOG2N passes the bank is in natural order.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            nxt[i] = bank[i];
        end
        for (int k = 0; k < H; k++) begin
            nxt[2*k]   = bank[k] + bank[k+H];
            nxt[2*k+1] = bank[k] - bank[k+H];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Ready <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Out   <= '0;
            for (int i = 0; i < N; i++) begin
                bank[i] <= '0;
            end
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (FhtStar) begin
                        for (int i = 0; i < N; i++) begin
                            bank[i] <= ld[i];
                        end
                        cnt   <= '0;
                        state <= RUN;
                        Ready <= 1'b0;
                        Busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        bank[i] <= nxt[i];
                    end
                    if (last) begin
                        for (int j = 0; j < N; j++) begin
                            Out[j*OUT_W +: OUT_W] <= nxt[j];
                        end
                        state <= DONE;
                        Done  <= 1'b1;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Ready <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
